// File: rtl/sop_truth_table_scanner.sv
// sop_truth_table_scanner
//   Walks an N_IN-bit stimulus through every input combination, holds each
//   value for SETTLE cycles, samples the function output, and builds the
//   minterm mask. It also counts the ones and compares the mask with EXPECTED.
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_start  scan request, accepted only in IDLE
//   i_f_in   output of the function under test (synchronous to i_clk)
//   o_stim   stimulus to the function; o_stim[N_IN-1] is the MSB input
//   o_busy   scan in progress
//   o_done   one-cycle pulse when the results become valid
//   o_mask   captured truth table; bit i = f_in sampled with stim == i
//   o_ones   population count of o_mask
//   o_match  o_mask == EXPECTED, valid from o_done onwards
module sop_truth_table_scanner #(
  parameter int                   N_IN     = 3,
  parameter int                   SETTLE   = 2,
  parameter logic [2**N_IN-1:0]   EXPECTED = 8'b1000_0011
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_f_in,
  output logic [N_IN-1:0]      o_stim,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2**N_IN-1:0]   o_mask,
  output logic [N_IN:0]        o_ones,
  output logic                 o_match
);

  localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST      = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [N_IN-1:0]     r_stim;
  logic                r_busy, r_done, r_match;
  logic [2**N_IN-1:0]  r_mask;
  logic [N_IN:0]       r_ones;
  logic                w_sample;

  // Sample edge: the stimulus has now been held for SETTLE cycles.
  assign w_sample = (r_cnt == SETTLE_M1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = SCAN;
      SCAN:    if (w_sample && r_stim == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_stim  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mask  <= '0;
      r_ones  <= '0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy  <= 1'b1;
            r_stim  <= '0;
            r_mask  <= '0;
            r_ones  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
          end
        end
        SCAN: begin
          if (!w_sample) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_mask[r_stim] <= i_f_in;
            r_ones         <= r_ones + {{N_IN{1'b0}}, i_f_in};
            r_cnt          <= '0;
            // The stimulus is held on the last minterm rather than wrapped.
            if (r_stim != LAST) r_stim <= r_stim + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_match <= (r_mask == EXPECTED);
          r_stim  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_stim  = r_stim;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_mask  = r_mask;
  assign o_ones  = r_ones;
  assign o_match = r_match;

endmodule

// File: tb/tb_sop_truth_table_scanner.sv
module tb_sop_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start1 = 1'b0;
  logic       f_in, f_in1;
  logic [1:0] mode = 2'd0;
  logic       glitch = 1'b0;

  logic [2:0] stim, stim1;
  logic       busy, done, match, busy1, done1, match1;
  logic [7:0] mask, mask1;
  logic [3:0] ones, ones1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sop_truth_table_scanner dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_f_in(f_in),
    .o_stim(stim), .o_busy(busy), .o_done(done), .o_mask(mask),
    .o_ones(ones), .o_match(match)
  );

  sop_truth_table_scanner #(.N_IN(3), .SETTLE(1), .EXPECTED(8'b1000_0011)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_f_in(f_in1),
    .o_stim(stim1), .o_busy(busy1), .o_done(done1), .o_mask(mask1),
    .o_ones(ones1), .o_match(match1)
  );

  // Function under test: 0 = a'b'c' + a'b'c + abc, 1 = tied 0, 2 = tied 1, 3 = c
  always_comb begin
    f_in = 1'b0;
    case (mode)
      2'd0: f_in = (~stim[2] & ~stim[1]) | (&stim);
      2'd1: f_in = 1'b0;
      2'd2: f_in = 1'b1;
      2'd3: f_in = stim[0];
      default: f_in = 1'b0;
    endcase
    f_in = f_in | glitch;
  end
  assign f_in1 = stim1[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a negedge: start is seen at the next posedge (edge 0).
  task automatic start_scan();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Steps edges 1..17 of a scan and checks the result after edge 17.
  // rs1/rs2: edges at which start is re-pulsed; gl: edge during which f_in glitches.
  task automatic body(input int rs1, input int rs2, input int gl,
                      input logic [7:0] em, input logic [3:0] eo,
                      input logic em_t, input logic tail);
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk);
      if (e == 1) begin
        chk("busy_at_start", busy, 1'b1);
        chk("mask_cleared", mask, 8'h00);
        chk("ones_cleared", ones, 4'd0);
        chk("match_cleared", match, 1'b0);
        chk("done_at_start", done, 1'b0);
      end
      if (e == 4)  chk("stim_mid", stim, 3'd1);
      if (e == 17) begin
        chk("stim_last", stim, 3'd7);
        chk("done_early", done, 1'b0);
        chk("busy_before_done", busy, 1'b1);
      end
      start  = (e == rs1 || e == rs2);
      glitch = (e == gl);
      @(posedge clk);
      #1 start = 1'b0;
    end
    glitch = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("busy_low", busy, 1'b0);
    chk("mask", mask, em);
    chk("ones", ones, eo);
    chk("match", match, em_t);
    chk("stim_zero", stim, 3'd0);
    if (tail) begin
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("mask_hold", mask, em);
      chk("match_hold", match, em_t);
    end
  endtask

  initial begin
    int ndone;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mask", mask, 8'h00);
    chk("rst_ones", ones, 4'd0);
    chk("rst_match", match, 1'b0);
    chk("rst_stim", stim, 3'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: default function
    mode = 2'd0;
    start_scan();
    body(0, 0, 0, 8'b1000_0011, 4'd3, 1'b1, 1'b1);

    // 2: tied 0 then tied 1
    mode = 2'd1;
    start_scan();
    body(0, 0, 0, 8'h00, 4'd0, 1'b0, 1'b1);
    mode = 2'd2;
    start_scan();
    body(0, 0, 0, 8'hFF, 4'd8, 1'b0, 1'b1);

    // 3: restarts during scan ignored; start in done cycle accepted
    mode = 2'd0;
    start_scan();
    body(5, 10, 0, 8'b1000_0011, 4'd3, 1'b1, 1'b0);
    start_scan();
    body(0, 0, 0, 8'b1000_0011, 4'd3, 1'b1, 1'b1);

    // 4: asynchronous reset mid-scan
    start_scan();
    for (int e = 1; e <= 9; e++) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_mask", mask, 8'b0000_0011);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_mask", mask, 8'h00);
    chk("arst_ones", ones, 4'd0);
    chk("arst_stim", stim, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    start_scan();
    body(0, 0, 0, 8'b1000_0011, 4'd3, 1'b1, 1'b1);

    // 6: f_in glitch high across non-sample edge 5 (stim=2, f=0)
    start_scan();
    body(0, 0, 5, 8'b1000_0011, 4'd3, 1'b1, 1'b1);

    // 5: SETTLE=1, f_in = c
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int e = 1; e <= 8; e++) @(posedge clk);
    @(negedge clk);
    chk("s1_done_early", done1, 1'b0);
    chk("s1_busy", busy1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("s1_done", done1, 1'b1);
    chk("s1_mask", mask1, 8'b1010_1010);
    chk("s1_ones", ones1, 4'd4);
    chk("s1_match", match1, 1'b0);
    @(negedge clk);
    chk("s1_done_drop", done1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sop_truth_table_scanner.md
Name: sop_truth_table_scanner

Overview:
- Sequential characteriser for small combinational logic blocks such as sum-of-products functions.
- On start, steps an N_IN-bit stimulus vector through every input combination, waits SETTLE cycles at each one, then samples the function output.
- Builds the full truth table as a minterm mask, counts the ones, and compares the result against an expected mask.
- Used on-board and in benches to check SOP/POS blocks without a host.

Parameters:
- N_IN, 3: number of function inputs; scan covers 2**N_IN combinations.
- SETTLE, 2: cycles each stimulus is held before sampling; legal range 1..15.
- EXPECTED, 8'b1000_0011: expected minterm mask, width 2**N_IN; bit i = expected output for input value i.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- f_in  input  1  output of the function under test.
- stim  output  N_IN  stimulus to the function under test; stim[N_IN-1] is the MSB input (a), stim[0] the LSB input (c).
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the results become valid.
- mask  output  2**N_IN  captured truth table; bit i = f_in sampled with stim==i.
- ones  output  N_IN+1  number of set bits in mask.
- match  output  1  high when mask == EXPECTED; valid from done onwards.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: stim=0, busy=0, done=0, mask=0, ones=0, match=0; state=IDLE; settle counter=0.
- All outputs are registered.
- States:
  - IDLE -> SCAN on start.
  - SCAN -> SCAN while minterms remain.
  - SCAN -> DONE after the sample for stim == 2**N_IN-1.
  - DONE -> IDLE unconditionally after one cycle.
- Start edge k (start=1 in IDLE): busy=1, stim=0, mask=0, ones=0, match=0, counter=0.
- SCAN, counter < SETTLE-1: counter increments; stim is held.
- SCAN, counter == SETTLE-1:
  - mask[stim] <= f_in; ones <= ones + f_in; counter <= 0.
  - If stim == 2**N_IN-1, go to DONE with stim held; otherwise stim <= stim+1.
- Minterm i is therefore sampled at edge k+(i+1)*SETTLE; the last sample is at edge k+(2**N_IN)*SETTLE.
- DONE edge (k+(2**N_IN)*SETTLE+1): done=1, busy=0, match=(mask==EXPECTED), stim=0, state=IDLE.
- Next edge: done=0.
- mask, ones and match hold their values until the next accepted start or reset.
- start while busy (SCAN or DONE) is ignored; there is no queueing.
- start high in the cycle where done=1 (already IDLE) is accepted: done drops and the new scan clears the results.
- start held high continuously causes back-to-back scans, one accepted per return to IDLE.
- f_in is used only on the sample edge; glitches between sample edges are irrelevant.
- f_in must be synchronous to clk; the block provides no synchroniser.
- ones cannot overflow: maximum 2**N_IN fits in N_IN+1 bits.
- stim wrap: stim never increments past 2**N_IN-1.
- Reset asserted mid-scan: immediate return to reset values; the partial mask is discarded; no done pulse.
- Total latency from the start edge to done high is (2**N_IN)*SETTLE+1 cycles (17 for the defaults).

Test Plan:
1. Defaults; f_in = a'b'c' + a'b'c + abc driven from stim; start pulsed at edge 0 -> samples at edges 2,4,...,16; done high after edge 17 for exactly 1 cycle; mask=8'b1000_0011, ones=4'd3, match=1, busy low from edge 17.
2. f_in tied 0, then tied 1 -> first run: mask=8'h00, ones=0, match=0; second run: mask=8'hFF, ones=8, match=0.
3. Same function as scenario 1; start re-pulsed at edges 5 and 10 during the scan -> no restart; done still after edge 17 with the identical result; start in the done cycle -> new scan begins, mask cleared to 0 at that edge.
4. rst asserted mid-cycle between edges 9 and 10 -> outputs go to 0 without waiting for a clock; no done pulse; a subsequent start yields the scenario-1 result.
5. SETTLE=1, f_in = stim[0] (c) -> mask=8'b1010_1010, ones=4, match=0, done high after edge 9.
6. Same function as scenario 1, but f_in forced to 1 for one cycle between sample edges -> mask unaffected, still 8'b1000_0011.
